multdiv_iter_param: RTL

- Parametrised iterative multiply/divide unit: radix-2, one bit per cycle, for MUL, MULH, DIV and REM at any operand width.
- Successor to the shared-adder slow multdiv:
  - owns its adder and negators, so no ALU operand muxing;
  - valid/ready handshakes on both request and result;
  - kill_i abort;
  - fixed, documented latency;
  - early termination on divide-by-zero.
- Sits beside the ALU in the execute stage and serves the RV32M/RV64M-style ops.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_cond_neg.sv | 17 +
 rtl/multdiv_iter_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   md_op_e    : operation select carried on operator_i
//   md_state_e : control FSM states
package multdiv_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StComp,
    StFix,
    StDone
  } md_state_e;

endpackage

// File: rtl/multdiv_cond_neg.sv
// Conditional two's-complement negator.
//   neg_i : when high, out_o = -in_i, otherwise out_o = in_i
//   in_i  : N-bit operand
//   out_o : N-bit result
module multdiv_cond_neg #(
  parameter int unsigned N = 32
) (
  input  logic         neg_i,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o
);

  always_comb begin
    out_o = neg_i ? ((~in_i) + N'(1)) : in_i;
  end

endmodule

// File: rtl/multdiv_iter_param.sv
// Iterative radix-2 multiply/divide unit (MUL, MULH, DIV, REM), one bit per cycle.
// Operands are converted to magnitudes at accept, iterated unsigned, and the sign is
// applied in a single fix-up cycle. Divide-by-zero bypasses the iteration.
//   clk, rst_n          : clock, synchronous active-low reset
//   valid_i / ready_o   : request handshake (ready_o high only in idle)
//   kill_i              : abort, returns to idle without a result
//   operator_i          : md_op_e
//   signed_mode_i       : bit0 = op_a signed, bit1 = op_b signed
//   op_a_i, op_b_i      : multiplicand/dividend, multiplier/divisor
//   valid_o / ready_i   : result handshake, result_o held while stalled
//   busy_o              : unit not idle
module multdiv_iter_param
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             kill_i,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  // MUL: {partial high, multiplier/low product}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               sign_a_in, sign_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic               is_div_in, is_div_q;

  assign sign_a_in = op_a_i[WIDTH-1] & signed_mode_i[0];
  assign sign_b_in = op_b_i[WIDTH-1] & signed_mode_i[1];
  assign is_div_in = (operator_i == MD_OP_DIV) || (operator_i == MD_OP_REM);
  assign is_div_q  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

  multdiv_cond_neg #(.N(WIDTH)) u_neg_a (
    .neg_i (sign_a_in),
    .in_i  (op_a_i),
    .out_o (mag_a_in)
  );

  multdiv_cond_neg #(.N(WIDTH)) u_neg_b (
    .neg_i (sign_b_in),
    .in_i  (op_b_i),
    .out_o (mag_b_in)
  );

  // Shift-add multiply step: add |a| to the high half when the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step. Remainder stays below |b|, so the shifted remainder fits
  // in WIDTH+1 bits and the difference MSB is a reliable borrow.
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, mag_b_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix-up shares one 2W-bit negator across all operations.
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic               fix_neg;
  always_comb begin
    fix_in  = acc_q;
    fix_neg = sign_a_q ^ sign_b_q;
    unique case (op_q)
      MD_OP_MULL, MD_OP_MULH: fix_in = acc_q;
      MD_OP_DIV: fix_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
      MD_OP_REM: begin
        fix_in  = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
        fix_neg = sign_a_q;
      end
      default: fix_in = acc_q;
    endcase
  end

  multdiv_cond_neg #(.N(2 * WIDTH)) u_neg_fix (
    .neg_i (fix_neg),
    .in_i  (fix_in),
    .out_o (fix_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (kill_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            op_d     = md_op_e'(operator_i);
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            mag_a_d  = mag_a_in;
            mag_b_d  = mag_b_in;
            if (is_div_in && (op_b_i == '0)) begin
              state_d  = StDone;
              result_d = (operator_i == MD_OP_REM) ? op_a_i : '1;
            end else begin
              state_d = StComp;
              cnt_d   = CNT_W'(WIDTH - 1);
              acc_d   = is_div_in ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
            end
          end
        end
        StComp: begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StFix: begin
          result_d = (op_q == MD_OP_MULH) ? fix_out[2*WIDTH-1:WIDTH] : fix_out[WIDTH-1:0];
          state_d  = StDone;
        end
        StDone: begin
          if (ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= MD_OP_MULL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q != StIdle);
  assign valid_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule
